// File: rtl/add_sub_np.sv
// Segmented pipelined adder/subtractor: one SEG-bit carry segment per stage, registered carry between stages.
// Define ADD_SUB_NP_SAT_EN to build signed saturation into the final stage.
module add_sub_np #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    // Operand skew registers are packed triangularly: stage k keeps only the
    // (STAGES-k) segments still to be added; partial sums grow by one segment per stage.
    function automatic int aoff(input int k);
        return SEG * (k * STAGES - (k * (k - 1)) / 2);
    endfunction

    function automatic int poff(input int k);
        return SEG * ((k * (k - 1)) / 2);
    endfunction

    localparam int AW   = aoff(STAGES);
    localparam int PW   = (STAGES > 1) ? poff(STAGES) : 1;
    localparam int AMSB = aoff(STAGES - 1) + SEG - 1;
    localparam int AIW  = (AW > 2) ? $clog2(AW) : 1;
    localparam int PIW  = (PW > 2) ? $clog2(PW) : 1;
    localparam int WIW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CIW  = (STAGES > 2) ? $clog2(STAGES) : 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("add_sub_np: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [AW-1:0]    a_q, a_d, b_q, b_d;
    logic [PW-1:0]    p_q, p_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES:0]  vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [SEG:0]     t;

    always_comb begin
        a_d        = '0;
        b_d        = '0;
        p_d        = '0;
        c_d        = '0;
        sum_d      = '0;
        cout_d     = 1'b0;
        ovf_d      = 1'b0;
        t          = '0;
        vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_valid};

        // Stage 0: subtract is x + ~y + 1, the +1 entering as carry-in.
        a_d[WIDTH-1:0] = x;
        b_d[WIDTH-1:0] = sub ? ~y : y;
        c_d[0]         = sub;

        for (int k = 1; k < STAGES; k++) begin
            t = {1'b0, a_q[AIW'(aoff(k - 1)) +: SEG]} + {1'b0, b_q[AIW'(aoff(k - 1)) +: SEG]}
              + {{SEG{1'b0}}, c_q[CIW'(k - 1)]};
            for (int i = 0; i < (STAGES - k) * SEG; i++) begin
                a_d[AIW'(aoff(k) + i)] = a_q[AIW'(aoff(k - 1) + SEG + i)];
                b_d[AIW'(aoff(k) + i)] = b_q[AIW'(aoff(k - 1) + SEG + i)];
            end
            for (int i = 0; i < (k - 1) * SEG; i++) begin
                p_d[PIW'(poff(k) + i)] = p_q[PIW'(poff(k - 1) + i)];
            end
            p_d[PIW'(poff(k) + (k - 1) * SEG) +: SEG] = t[SEG-1:0];
            c_d[CIW'(k)] = t[SEG];
        end

        // Final stage adds the top segment straight into the output register.
        t = {1'b0, a_q[AIW'(aoff(STAGES - 1)) +: SEG]} + {1'b0, b_q[AIW'(aoff(STAGES - 1)) +: SEG]}
          + {{SEG{1'b0}}, c_q[CIW'(STAGES - 1)]};
        for (int i = 0; i < (STAGES - 1) * SEG; i++) begin
            sum_d[WIW'(i)] = p_q[PIW'(poff(STAGES - 1) + i)];
        end
        sum_d[WIDTH-1 -: SEG] = t[SEG-1:0];
        cout_d = t[SEG];
        ovf_d  = (a_q[AMSB] == b_q[AMSB]) && (t[SEG-1] != a_q[AMSB]);
`ifdef ADD_SUB_NP_SAT_EN
        if (ovf_d) begin
            sum_d = a_q[AMSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            c_q        <= '0;
            vld_pipe_q <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (ce) begin
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            c_q        <= c_d;
            vld_pipe_q <= vld_pipe_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_np.sv
// Directed bench for add_sub_np (WIDTH=16, STAGES=4, latency 5); expected values hand-computed.
module tb_add_sub_np;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, sub;
    logic [15:0] x, y, sum;
    logic        out_valid, cout, ovf;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    add_sub_np #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .x(x), .y(y), .sub(sub),
        .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf)
    );

    logic [15:0] vx[8] = '{16'h1234, 16'hA000, 16'hFFFF, 16'h0001, 16'h4000, 16'h8001, 16'h0F0F, 16'h0000};
    logic [15:0] vy[8] = '{16'h1111, 16'h2000, 16'hFFFF, 16'h0001, 16'h4000, 16'h0002, 16'hF0F0, 16'h8000};
    logic        vs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ADD_SUB_NP_SAT_EN
    logic [15:0] es[8] = '{16'h2345, 16'h8000, 16'hFFFE, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF};
    localparam logic [15:0] E_7FFF_P1 = 16'h7FFF;
    localparam logic [15:0] E_8000_M1 = 16'h8000;
`else
    logic [15:0] es[8] = '{16'h2345, 16'h8000, 16'hFFFE, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000};
    localparam logic [15:0] E_7FFF_P1 = 16'h8000;
    localparam logic [15:0] E_8000_M1 = 16'h7FFF;
`endif
    logic        ec[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        eo[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One isolated sample: out_valid must stay low for 4 edges and rise on the 5th.
    task automatic run_one(input string tag, input logic [15:0] xa, input logic [15:0] yb,
                           input logic s, input logic [15:0] e_sum, input logic e_cout,
                           input logic e_ovf);
        x = xa; y = yb; sub = s; in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            in_valid = 1'b0;
            if (i < 5) chk({tag, " early_valid"}, 16'(out_valid), 16'h0);
        end
        chk({tag, " valid"}, 16'(out_valid), 16'h1);
        chk({tag, " sum"},   sum,            e_sum);
        chk({tag, " cout"},  16'(cout),      16'(e_cout));
        chk({tag, " ovf"},   16'(ovf),       16'(e_ovf));
    endtask

    // Back-to-back stream of the 8 vectors with an optional ce stall window.
    task automatic stream(input string tag, input int st_start, input int st_len);
        logic mv[5];
        int   mi[5];
        int   p     = 0;
        int   n_out = 0;
        for (int j = 0; j < 5; j++) begin mv[j] = 1'b0; mi[j] = 0; end
        for (int c = 0; c < 22; c++) begin
            ce = !(c >= st_start && c < st_start + st_len);
            if (p < 8) begin
                x = vx[p]; y = vy[p]; sub = vs[p]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (ce) begin
                for (int j = 4; j > 0; j--) begin mv[j] = mv[j-1]; mi[j] = mi[j-1]; end
                mv[0] = in_valid;
                mi[0] = p;
                if (p < 8) p++;
                if (out_valid === 1'b1) n_out++;
            end
            chk({tag, " out_valid"}, 16'(out_valid), 16'(mv[4]));
            if (mv[4]) begin
                chk({tag, " sum"},  sum,       es[mi[4]]);
                chk({tag, " cout"}, 16'(cout), 16'(ec[mi[4]]));
                chk({tag, " ovf"},  16'(ovf),  16'(eo[mi[4]]));
            end
        end
        ce = 1'b1;
        chk({tag, " result_count"}, 16'(n_out), 16'd8);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; sub = 1'b0; x = '0; y = '0;
        tick();
        tick();
        chk("reset out_valid", 16'(out_valid), 16'h0);
        chk("reset sum",       sum,            16'h0);
        chk("reset cout",      16'(cout),      16'h0);
        chk("reset ovf",       16'(ovf),       16'h0);
        reset = 1'b0;

        run_one("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, E_7FFF_P1, 1'b0, 1'b1);
        run_one("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000,  1'b1, 1'b0);
        run_one("sub_5_7",    16'h0005, 16'h0007, 1'b1, 16'hFFFE,  1'b0, 1'b0);
        run_one("sub_8000_1", 16'h8000, 16'h0001, 1'b1, E_8000_M1, 1'b1, 1'b1);

        stream("stream", 100, 0);
        stream("stall",  3,   3);

        // Three samples in flight, then reset together with ce=0 and a new sample.
        for (int j = 0; j < 3; j++) begin
            x = vx[j]; y = vy[j]; sub = vs[j]; in_valid = 1'b1;
            tick();
        end
        reset = 1'b1; ce = 1'b0; x = vx[3]; y = vy[3]; sub = vs[3]; in_valid = 1'b1;
        tick();
        chk("rst_flight out_valid", 16'(out_valid), 16'h0);
        chk("rst_flight sum",       sum,            16'h0);
        chk("rst_flight cout",      16'(cout),      16'h0);
        chk("rst_flight ovf",       16'(ovf),       16'h0);
        reset = 1'b0; ce = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_flight no_stale_valid", 16'(out_valid), 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_sub_np.md
# add_sub_np

Parametrised, segmented pipelined adder/subtractor, the next generation of the two-stage split-carry adder. The operand width is split into `STAGES` equal segments. Each pipeline stage adds one segment and registers its carry into the next stage, so the adder reaches high clock rates at any width. On top of the earlier design it adds a per-sample add/subtract mode, valid tracking, a clock-enable stall, synchronous reset, carry-out and signed-overflow flags. It sits in the DSP datapath wherever a wide accumulate or difference term must meet timing.

## Interface
- `WIDTH`, 16: total operand and result width. Must be an exact multiple of `STAGES`; any other value is an elaboration error.
- `STAGES`, 4: number of carry segments and adder stages, 1..`WIDTH`. Segment width is `SEG = WIDTH/STAGES`.
- `clk`, in, 1: clock. All registers update on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `ce`, in, 1: clock enable. While 0, every pipeline register holds its value.
- `in_valid`, in, 1: `x`, `y` and `sub` carry a sample this cycle.
- `x`, in, `WIDTH`: operand A, two's complement.
- `y`, in, `WIDTH`: operand B, two's complement.
- `sub`, in, 1: 0 computes x+y; 1 computes x−y.
- `out_valid`, out, 1: `sum`, `cout` and `ovf` are valid this cycle.
- `sum`, out, `WIDTH`: result.
- `cout`, out, 1: carry out of the MSB. In subtract mode it is the not-borrow.
- `ovf`, out, 1: signed overflow of the result.

## Operation
- **Input stage (stage 0):** on `ce`=1, register `x`, `y` and `sub`. Store the effective B as `y` when `sub`=0 and as `~y` when `sub`=1. Register `cin = sub` and `valid = in_valid`.
- **Adder stage k (1..STAGES):** add segment k−1 of A and effective B plus the carry registered by stage k−1. Stage 1 uses `cin` as its carry.
  - Register the SEG-bit partial sum and the carry out.
  - Delay the already-finished lower sum segments unchanged.
  - Delay the not-yet-added upper operand segments unchanged (skew registers).
- **Final stage:** stage `STAGES` is the output register.
  - `sum` = concatenation of all segment results.
  - `cout` = carry out of the top segment.
  - `ovf` = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
- **Valid:** a `valid` bit travels alongside the data through every stage. Data registers load regardless of valid when `ce`=1. Outputs are don't-care while `out_valid`=0, but must equal their last loaded values.
- **Throughput:** no backpressure. One sample per `ce` cycle.
- **Arithmetic:** results are modulo 2^WIDTH with wrap-around, except as changed under Configuration.
- **Full carry ripple:** for 0xFFFF+1 the carry propagates through all stages with no extra latency.
- **STAGES=1:** a single full-width adder stage; latency 2.

## Timing
- **Latency:** `STAGES`+1 enabled cycles from the sampling edge to `out_valid`. With default parameters that is 5.
- **Reset:** `reset`=1 at a rising edge clears all valid bits, all data registers, `sum`, `cout`, `ovf` and `out_valid` to 0.
  - `reset` has priority over `ce`.
  - Samples in flight are discarded; no stale result ever asserts `out_valid` after reset.
- **Stall:** `ce`=0 freezes the whole pipeline, outputs included. `out_valid` stays at its frozen value, so the consumer must qualify with `ce`. On release, flow resumes with no sample lost or duplicated.
- **Idle cycles:** `in_valid`=0 with `ce`=1 inserts a bubble that exits exactly `STAGES`+1 cycles later with `out_valid`=0.
- **Simultaneous events:** `in_valid`=1 together with `reset`=1 means the sample is dropped.

## Configuration
- `ADD_SUB_NP_SAT_EN` defined: signed saturation in the final stage.
  - When `ovf`=1, `sum` is 0x7FFF.. if A[MSB]=0, else 0x8000...
  - `ovf` and `cout` still report the raw flags.
  - Latency is unchanged.
- Macro not defined: `sum` wraps modulo 2^WIDTH. No saturation logic is built.

## Test plan
All scenarios use WIDTH=16, STAGES=4, latency 5.
- Add 0x7FFF+0x0001 -> `sum`=0x8000, `ovf`=1, `cout`=0. With `ADD_SUB_NP_SAT_EN`: `sum`=0x7FFF, `ovf`=1.
- Add 0xFFFF+0x0001 -> `sum`=0x0000, `cout`=1, `ovf`=0, 5 cycles after sampling (full 4-segment ripple).
- Subtract 0x0005−0x0007 -> `sum`=0xFFFE, `cout`=0, `ovf`=0. Subtract 0x8000−0x0001 -> `sum`=0x7FFF, `ovf`=1 (saturated build: 0x8000).
- Stream 8 back-to-back random samples with mixed `sub` -> 8 consecutive `out_valid` cycles, in order, matching the reference model, starting at cycle 5.
- Drop `ce` for 3 cycles mid-stream -> outputs frozen for 3 cycles. After release all 8 results appear in order, none lost or duplicated.
- Assert `reset` for 1 cycle with 3 samples in flight -> all outputs 0 the next cycle. No `out_valid` during the following 5 cycles unless new samples are issued.
